// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Sizing: N is the extended operand width, NE is N rounded up to even, ITER is the iteration count.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_t;

    function automatic int calc_n(input int width);
        return width + 1;
    endfunction

    function automatic int calc_ne(input int width);
        return calc_n(width) + (calc_n(width) % 2);
    endfunction

    function automatic int calc_iter(input int width, input bit radix4);
        return radix4 ? calc_ne(width) / 2 : calc_n(width);
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth digit recoder: maps a 3-bit multiplier window to a signed digit and the
// matching NE+1-bit addend. For radix-2, drive the window as {q0, q0, q_m1}.
module booth_recoder
    import booth_pkg::*;
#(
    parameter int NE = 10
) (
    input  logic [2:0]    window,
    input  logic [NE-1:0] m,
    output digit_t        digit,
    output logic [NE:0]   addend
);

    logic [NE:0] m1;
    logic [NE:0] m2;

    assign m1 = {m[NE-1], m};
    // m holds a sign-extended N-bit value with N <= NE, so doubling still fits in NE+1 bits
    assign m2 = {m, 1'b0};

    always_comb begin
        digit = ZERO;
        case (window)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

    always_comb begin
        addend = '0;
        case (digit)
            P1:      addend = m1;
            P2:      addend = m2;
            M1:      addend = -m1;
            M2:      addend = -m2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, radix-2 or radix-4, one recoding step per clock,
// with a start/busy/done handshake and a held product register.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit RADIX4 = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N     = calc_n(WIDTH);
    localparam int NE    = calc_ne(WIDTH);
    localparam int ITER  = calc_iter(WIDTH, RADIX4);
    localparam int STEP  = RADIX4 ? 2 : 1;
    // Radix-2 only shifts N times, so the product sits NE-N bits up in {A,Q}
    localparam int OFF   = NE - ITER * STEP;
    localparam int CNT_W = $clog2(ITER);

    state_t             state_reg;
    logic [NE:0]        a_reg;
    logic [NE-1:0]      q_reg;
    logic               qm1_reg;
    logic [NE-1:0]      m_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] product_reg;

    logic [NE-1:0]      mcand_ext;
    logic [NE-1:0]      mplier_ext;
    logic [2:0]         window;
    digit_t             digit;
    logic [NE:0]        addend;
    logic [NE:0]        sum;
    logic [2*NE+1:0]    shifted;
    logic [NE:0]        a_next;
    logic [NE-1:0]      q_next;
    logic               qm1_next;

    assign mcand_ext  = {{(NE-WIDTH){signed_op & multiplicand[WIDTH-1]}}, multiplicand};
    assign mplier_ext = {{(NE-WIDTH){signed_op & multiplier[WIDTH-1]}}, multiplier};

    assign window = RADIX4 ? {q_reg[1], q_reg[0], qm1_reg} : {q_reg[0], q_reg[0], qm1_reg};

    booth_recoder #(
        .NE(NE)
    ) u_recoder (
        .window (window),
        .m      (m_reg),
        .digit  (digit),
        .addend (addend)
    );

    assign sum     = (digit == ZERO) ? a_reg : a_reg + addend;
    assign shifted = $signed({sum, q_reg, qm1_reg}) >>> STEP;

    assign a_next   = shifted[2*NE+1:NE+1];
    assign q_next   = shifted[NE:1];
    assign qm1_next = shifted[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            m_reg       <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    // busy is still high during the done cycle, which blocks a new accept there
                    if (start && !busy_reg) begin
                        m_reg     <= mcand_ext;
                        q_reg     <= mplier_ext;
                        a_reg     <= '0;
                        qm1_reg   <= 1'b0;
                        cnt_reg   <= CNT_W'(ITER - 1);
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                CALC: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    qm1_reg <= qm1_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    product_reg <= (2*WIDTH)'({a_reg, q_reg} >> OFF);
                    done_reg    <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule
